// File: rtl/rasterizer_mem_pkg.sv
`default_nettype none
//==============================================================================
// Module   : rasterizer_mem_pkg
// Desc     : Shared SDRAM bus widths and arbiter state encoding for the
//            rasterizer memory path.
// Revision : 1.0 - initial release
//==============================================================================
package rasterizer_mem_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_BE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } arb_state_t;

endpackage : rasterizer_mem_pkg
`default_nettype wire

// File: rtl/rasterizer_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : rasterizer_mem_arbiter
// Desc     : Round-robin arbiter sharing one SDRAM Avalon-MM pipelined master
//            between the depth-fetch read port and the writeback write port.
// Revision : 1.0 - initial release
//==============================================================================
module rasterizer_mem_arbiter
    import rasterizer_mem_pkg::*;
#(
    parameter int MAX_BEATS       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic [SDRAM_ADDR_W-1:0] rd_address,
    input  logic                    rd_read,
    input  logic [SDRAM_BE_W-1:0]   rd_byteenable,
    output logic                    rd_waitrequest,
    output logic [SDRAM_DATA_W-1:0] rd_readdata,
    output logic                    rd_readdatavalid,

    input  logic [SDRAM_ADDR_W-1:0] wr_address,
    input  logic                    wr_write,
    input  logic [SDRAM_BE_W-1:0]   wr_byteenable,
    input  logic [SDRAM_DATA_W-1:0] wr_writedata,
    output logic                    wr_waitrequest,

    output logic [SDRAM_ADDR_W-1:0] master_address,
    output logic                    master_read,
    output logic                    master_write,
    output logic [SDRAM_BE_W-1:0]   master_byteenable,
    output logic [SDRAM_DATA_W-1:0] master_writedata,
    input  logic [SDRAM_DATA_W-1:0] master_readdata,
    input  logic                    master_readdatavalid,
    input  logic                    master_waitrequest,

    output logic                    idle,
    output logic                    protocol_error
);

    localparam int c_BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int c_OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_MAX = c_BEAT_W'(MAX_BEATS);
    localparam logic [c_OUT_W-1:0]  c_OUT_MAX  = c_OUT_W'(MAX_OUTSTANDING);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                r_last_grant;
    logic                w_last_grant_next;
    logic [c_BEAT_W-1:0] r_beats;
    logic [c_BEAT_W-1:0] w_beats_next;
    logic [c_BEAT_W-1:0] w_beats_inc;
    logic [c_OUT_W-1:0]  r_outstanding;
    logic [c_OUT_W-1:0]  w_outstanding_next;
    logic                r_protocol_error;

    logic w_rd_fwd;
    logic w_wr_fwd;
    logic w_rd_accept;
    logic w_wr_accept;
    logic w_resp_ok;

    assign w_rd_fwd    = (r_state == S_READ) && rd_read && (r_outstanding < c_OUT_MAX);
    assign w_wr_fwd    = (r_state == S_WRITE) && wr_write;
    assign w_rd_accept = w_rd_fwd && !master_waitrequest;
    assign w_wr_accept = w_wr_fwd && !master_waitrequest;
    // A response with nothing in flight is stray: forwarded, flagged, not counted.
    assign w_resp_ok   = master_readdatavalid && (r_outstanding != '0);
    // Saturate so a long uncontested grant cannot wrap the beat counter.
    assign w_beats_inc = (r_beats == c_BEAT_MAX) ? r_beats : r_beats + c_BEAT_W'(1);

    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_rd_accept, w_resp_ok})
            2'b10:   w_outstanding_next = r_outstanding + c_OUT_W'(1);
            2'b01:   w_outstanding_next = r_outstanding - c_OUT_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_beats_next      = r_beats;
        master_address    = '0;
        master_read       = 1'b0;
        master_write      = 1'b0;
        master_byteenable = '0;
        master_writedata  = '0;
        rd_waitrequest    = 1'b1;
        wr_waitrequest    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (rd_read && (!wr_write || r_last_grant)) begin
                    w_state_next      = S_READ;
                    w_last_grant_next = 1'b0;
                    w_beats_next      = '0;
                end else if (wr_write) begin
                    w_state_next      = S_WRITE;
                    w_last_grant_next = 1'b1;
                    w_beats_next      = '0;
                end
            end
            S_READ: begin
                master_address    = rd_address;
                master_byteenable = rd_byteenable;
                master_read       = w_rd_fwd;
                rd_waitrequest    = !w_rd_accept;
                if (w_rd_accept) begin
                    w_beats_next = w_beats_inc;
                end
                // Limits count this cycle's accept so the grant ends on the last beat.
                if (!(w_rd_fwd && master_waitrequest) &&
                    (!rd_read ||
                     (w_beats_next == c_BEAT_MAX && wr_write) ||
                     (w_outstanding_next == c_OUT_MAX && wr_write))) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                master_address    = wr_address;
                master_byteenable = wr_byteenable;
                master_writedata  = wr_writedata;
                master_write      = wr_write;
                wr_waitrequest    = master_waitrequest;
                if (w_wr_accept) begin
                    w_beats_next = w_beats_inc;
                end
                if (!(w_wr_fwd && master_waitrequest) &&
                    (!wr_write || (w_beats_next == c_BEAT_MAX && rd_read))) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_last_grant     <= 1'b1;
            r_beats          <= '0;
            r_outstanding    <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_beats       <= w_beats_next;
            r_outstanding <= w_outstanding_next;
            if (master_readdatavalid && (r_outstanding == '0)) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    assign rd_readdata      = master_readdata;
    assign rd_readdatavalid = master_readdatavalid;
    assign idle             = (r_state == S_IDLE) && (r_outstanding == '0);
    assign protocol_error   = r_protocol_error;

endmodule : rasterizer_mem_arbiter
`default_nettype wire

// File: tb/tb_rasterizer_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_rasterizer_mem_arbiter
// Desc     : Self-checking bench for rasterizer_mem_arbiter: per-cycle vector
//            table, read-data scoreboard and hand-written corner sequences.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rasterizer_mem_arbiter;
    import rasterizer_mem_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [SDRAM_ADDR_W-1:0] rd_address;
    logic                    rd_read;
    logic [SDRAM_BE_W-1:0]   rd_byteenable;
    logic                    rd_waitrequest;
    logic [SDRAM_DATA_W-1:0] rd_readdata;
    logic                    rd_readdatavalid;
    logic [SDRAM_ADDR_W-1:0] wr_address;
    logic                    wr_write;
    logic [SDRAM_BE_W-1:0]   wr_byteenable;
    logic [SDRAM_DATA_W-1:0] wr_writedata;
    logic                    wr_waitrequest;
    logic [SDRAM_ADDR_W-1:0] master_address;
    logic                    master_read;
    logic                    master_write;
    logic [SDRAM_BE_W-1:0]   master_byteenable;
    logic [SDRAM_DATA_W-1:0] master_writedata;
    logic [SDRAM_DATA_W-1:0] master_readdata;
    logic                    master_readdatavalid;
    logic                    master_waitrequest;
    logic                    idle;
    logic                    protocol_error;

    always #5 clock = ~clock;

    rasterizer_mem_arbiter #(.MAX_BEATS(8), .MAX_OUTSTANDING(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .rd_address          (rd_address),
        .rd_read             (rd_read),
        .rd_byteenable       (rd_byteenable),
        .rd_waitrequest      (rd_waitrequest),
        .rd_readdata         (rd_readdata),
        .rd_readdatavalid    (rd_readdatavalid),
        .wr_address          (wr_address),
        .wr_write            (wr_write),
        .wr_byteenable       (wr_byteenable),
        .wr_writedata        (wr_writedata),
        .wr_waitrequest      (wr_waitrequest),
        .master_address      (master_address),
        .master_read         (master_read),
        .master_write        (master_write),
        .master_byteenable   (master_byteenable),
        .master_writedata    (master_writedata),
        .master_readdata     (master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_waitrequest  (master_waitrequest),
        .idle                (idle),
        .protocol_error      (protocol_error)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    // in  = {rd_read, wr_write, master_waitrequest, master_readdatavalid}
    // out = {master_read, master_write, rd_waitrequest, wr_waitrequest, idle, rd_readdatavalid, protocol_error}
    typedef struct {
        logic [3:0] in;
        logic [6:0] out;
        logic [2:0] outst;
    } vec_t;

    resp_t       mem_q[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          rd_acc   = 1'b0;
    bit          wr_acc   = 1'b0;
    logic [31:0] wr_n;

    function automatic logic [31:0] mem_data(input logic [SDRAM_ADDR_W-1:0] a);
        return 32'hDEADBEEF ^ {6'd0, a ^ 26'h100};
    endfunction

    function automatic vec_t mk(input logic [3:0] in, input logic [6:0] out, input int outst);
        vec_t v;
        v.in    = in;
        v.out   = out;
        v.outst = 3'(outst);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_resp(input bit v);
        resp_t r;
        if (v) begin
            master_readdatavalid = 1'b1;
            if (mem_q.size() > 0) begin
                r = mem_q.pop_front();
                master_readdata = r.data;
            end else begin
                master_readdata = 32'h0BAD0000;
            end
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
        end
    endtask

    // Memory model sees the master side; scoreboard sees the requester side.
    task automatic settle();
        #2;
        if (master_read && !master_waitrequest)
            mem_q.push_back('{data: mem_data(master_address), due: cyc + 2});
        if (rd_read && !rd_waitrequest) begin
            exp_q.push_back(mem_data(rd_address));
            rd_acc = 1'b1;
        end
        if (wr_write && !wr_waitrequest)
            wr_acc = 1'b1;
        if (rd_readdatavalid && exp_q.size() > 0)
            chk("rd_readdata", rd_readdata, exp_q.pop_front());
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
        if (rd_acc) rd_address = rd_address + 26'h1;
        if (wr_acc) begin
            wr_n         = wr_n + 32'd1;
            wr_address   = wr_address + 26'h1;
            wr_writedata = 32'hC0DE0000 + wr_n;
        end
        rd_acc = 1'b0;
        wr_acc = 1'b0;
    endtask

    task automatic apply_reset();
        rd_read            = 1'b0;
        wr_write           = 1'b0;
        master_waitrequest = 1'b0;
        set_resp(1'b0);
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        mem_q.delete();
        exp_q.delete();
        rd_address   = 26'h100;
        wr_address   = 26'h2000;
        wr_n         = '0;
        wr_writedata = 32'hC0DE0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pos;
        logic er, ew, ewr;

        reset         = 1'b1;
        rd_byteenable = 4'hF;
        wr_byteenable = 4'h3;
        rd_address    = 26'h100;
        wr_address    = 26'h2000;
        wr_writedata  = 32'hC0DE0000;
        wr_n          = '0;
        rd_read       = 1'b0;
        wr_write      = 1'b0;
        master_waitrequest = 1'b0;
        set_resp(1'b0);
        #1;
        apply_reset();

        settle();
        chk("reset_master_read", 32'(master_read), 32'd0);
        chk("reset_master_write", 32'(master_write), 32'd0);
        chk("reset_rd_wait", 32'(rd_waitrequest), 32'd1);
        chk("reset_wr_wait", 32'(wr_waitrequest), 32'd1);
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_perr", 32'(protocol_error), 32'd0);
        next_cycle();

        // single read, outstanding limit, limit-driven handover, accept+response, stray response
        vecs.push_back(mk(4'b1000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b1001000, 0));
        vecs.push_back(mk(4'b0000, 7'b0011000, 1));
        vecs.push_back(mk(4'b0000, 7'b0011000, 1));
        vecs.push_back(mk(4'b0001, 7'b0011010, 1));
        vecs.push_back(mk(4'b0000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b1001000, 0));
        vecs.push_back(mk(4'b1000, 7'b1001000, 1));
        vecs.push_back(mk(4'b1000, 7'b1001000, 2));
        vecs.push_back(mk(4'b1000, 7'b1001000, 3));
        vecs.push_back(mk(4'b1000, 7'b0011000, 4));
        vecs.push_back(mk(4'b1001, 7'b0011010, 4));
        vecs.push_back(mk(4'b1000, 7'b1001000, 3));
        vecs.push_back(mk(4'b1001, 7'b0011010, 4));
        vecs.push_back(mk(4'b1000, 7'b1001000, 3));
        vecs.push_back(mk(4'b0001, 7'b0011010, 4));
        vecs.push_back(mk(4'b0001, 7'b0011010, 3));
        vecs.push_back(mk(4'b0001, 7'b0011010, 2));
        vecs.push_back(mk(4'b0001, 7'b0011010, 1));
        vecs.push_back(mk(4'b0000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1100, 7'b1001000, 0));
        vecs.push_back(mk(4'b1100, 7'b1001000, 1));
        vecs.push_back(mk(4'b1100, 7'b1001000, 2));
        vecs.push_back(mk(4'b1100, 7'b1001000, 3));
        vecs.push_back(mk(4'b1100, 7'b0011000, 4));
        vecs.push_back(mk(4'b1100, 7'b0110000, 4));
        vecs.push_back(mk(4'b0001, 7'b0010010, 4));
        vecs.push_back(mk(4'b0001, 7'b0011010, 3));
        vecs.push_back(mk(4'b0001, 7'b0011010, 2));
        vecs.push_back(mk(4'b0001, 7'b0011010, 1));
        vecs.push_back(mk(4'b0000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b0011100, 0));
        vecs.push_back(mk(4'b1000, 7'b1001000, 0));
        vecs.push_back(mk(4'b1000, 7'b1001000, 1));
        vecs.push_back(mk(4'b1001, 7'b1001010, 2));
        vecs.push_back(mk(4'b0001, 7'b0011010, 2));
        vecs.push_back(mk(4'b0001, 7'b0011010, 1));
        vecs.push_back(mk(4'b0001, 7'b0011110, 0));
        vecs.push_back(mk(4'b0000, 7'b0011101, 0));
        vecs.push_back(mk(4'b0000, 7'b0011101, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rd_read            = vecs[i].in[3];
            wr_write           = vecs[i].in[2];
            master_waitrequest = vecs[i].in[1];
            set_resp(vecs[i].in[0]);
            settle();
            chk($sformatf("vec%0d", i),
                32'({master_read, master_write, rd_waitrequest, wr_waitrequest,
                     idle, rd_readdatavalid, protocol_error, dut.r_outstanding}),
                32'({vecs[i].out, vecs[i].outst}));
            if (vecs[i].out[6])
                chk($sformatf("vec%0d_addr", i), 32'(master_address), 32'(rd_address));
            next_cycle();
        end

        // both ports requesting continuously: 8 reads, bubble, 8 writes, bubble
        apply_reset();
        rd_read  = 1'b1;
        wr_write = 1'b1;
        for (int k = 0; k < 40; k++) begin
            set_resp(mem_q.size() > 0 && mem_q[0].due <= cyc);
            settle();
            pos = k % 18;
            er  = (pos >= 1 && pos <= 8);
            ew  = (pos >= 10);
            chk($sformatf("rr_cycle%0d", k), 32'({master_read, master_write}), 32'({er, ew}));
            next_cycle();
        end
        rd_read  = 1'b0;
        wr_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_resp(mem_q.size() > 0 && mem_q[0].due <= cyc);
            settle();
            next_cycle();
        end
        chk("rr_drained", 32'(exp_q.size()), 32'd0);

        // 8th write stalled for 5 cycles while reads wait
        apply_reset();
        wr_write = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            rd_read            = (k >= 5);
            master_waitrequest = (k >= 8 && k <= 12);
            set_resp(1'b0);
            settle();
            er  = (k == 15);
            ew  = (k >= 1 && k <= 13);
            ewr = !((k >= 1 && k <= 7) || k == 13);
            chk($sformatf("stall_k%0d", k),
                32'({master_read, master_write, wr_waitrequest}), 32'({er, ew, ewr}));
            if (k >= 8 && k <= 13)
                chk($sformatf("stall_wdata_k%0d", k), master_writedata, 32'hC0DE0007);
            next_cycle();
        end

        // reset while three reads are in flight
        apply_reset();
        rd_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_resp(1'b0);
            settle();
            next_cycle();
        end
        rd_read = 1'b0;
        reset   = 1'b0;
        settle();
        chk("pre_reset_outstanding", 32'(dut.r_outstanding), 32'd3);
        next_cycle();
        reset = 1'b1;
        settle();
        chk("post_reset_state",
            32'({master_read, master_write, rd_waitrequest, wr_waitrequest,
                 idle, protocol_error, dut.r_outstanding}),
            32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0}));
        next_cycle();
        set_resp(1'b1);
        settle();
        chk("late_rdv", 32'(rd_readdatavalid), 32'd1);
        chk("late_perr_before", 32'(protocol_error), 32'd0);
        next_cycle();
        set_resp(1'b1);
        settle();
        chk("late_perr_set", 32'(protocol_error), 32'd1);
        next_cycle();
        set_resp(1'b1);
        settle();
        chk("late_perr_sticky", 32'({protocol_error, dut.r_outstanding}), 32'({1'b1, 3'd0}));
        next_cycle();
        set_resp(1'b0);
        rd_read  = 1'b1;
        wr_write = 1'b1;
        settle();
        next_cycle();
        settle();
        chk("post_reset_tie_read_first", 32'({master_read, master_write}), 32'({1'b1, 1'b0}));
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rasterizer_mem_arbiter
`default_nettype wire

// File: doc/rasterizer_mem_arbiter.md
# rasterizer_mem_arbiter

Shares the single SDRAM Avalon-MM pipelined master between two rasterizer requesters: the depth fetch stage (read-only port `rd_*`) and the depth/colour writeback stage (write-only port `wr_*`). It grants the bus round-robin and holds a grant for up to `MAX_BEATS` accepted transfers. It bounds in-flight reads to `MAX_OUTSTANDING` and routes every read response back to the read port. It sits between the rasterizer pipeline stages and the SDRAM controller.

## Interface
- `MAX_BEATS`, default 8: maximum accepted transfers per grant when the other port is requesting.
- `MAX_OUTSTANDING`, default 4: maximum accepted reads without a `master_readdatavalid`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rd_address`  in  26  read word address.
- `rd_read`  in  1  read request; held until accepted.
- `rd_byteenable`  in  4  read byte enables.
- `rd_waitrequest`  out  1  read not accepted this cycle.
- `rd_readdata`  out  32  read return data.
- `rd_readdatavalid`  out  1  read return strobe.
- `wr_address`  in  26  write word address.
- `wr_write`  in  1  write request; held until accepted.
- `wr_byteenable`  in  4  write byte enables.
- `wr_writedata`  in  32  write data.
- `wr_waitrequest`  out  1  write not accepted this cycle.
- `master_address`  out  26  SDRAM address.
- `master_read`  out  1  SDRAM read.
- `master_write`  out  1  SDRAM write.
- `master_byteenable`  out  4  SDRAM byte enables.
- `master_writedata`  out  32  SDRAM write data.
- `master_readdata`  in  32  SDRAM read data.
- `master_readdatavalid`  in  1  SDRAM read data valid.
- `master_waitrequest`  in  1  SDRAM backpressure.
- `idle`  out  1  state is `S_IDLE` and no reads are outstanding.
- `protocol_error`  out  1  sticky; set when `master_readdatavalid` arrives while outstanding is 0.

## Operation
- States (`arb_state_t`): `S_IDLE`, `S_READ`, `S_WRITE`. Registers: `state`, `last_grant` (0=read, 1=write), `beats`, `outstanding`, `protocol_error`.
- **S_IDLE**: no request is forwarded.
  - Both ports requesting: grant the port opposite `last_grant`.
  - One port requesting: grant that port.
  - On grant: `beats` <= 0 and `last_grant` <= granted port.
- **S_READ**:
  - Master address, read and byteenable come from the `rd_*` inputs.
  - `master_read = rd_read && outstanding < MAX_OUTSTANDING`.
  - `rd_waitrequest = !(master_read && !master_waitrequest)`.
- **S_WRITE**:
  - Master address, write, byteenable and writedata come from the `wr_*` inputs.
  - `wr_waitrequest = master_waitrequest`.
- Outside its grant a port's waitrequest is 1. `master_writedata` and `master_byteenable` are 0 when not driven by a granted port.
- Accept = forwarded request && `!master_waitrequest`. Each accept increments `beats`.
- Release: go to `S_IDLE` at the next edge when any of these holds:
  - the granted request is low;
  - `beats` reaches `MAX_BEATS` and the other port is requesting;
  - in `S_READ`, `outstanding == MAX_OUTSTANDING` and `wr_write` is high.
- Release never occurs while a forwarded request is stalled by `master_waitrequest`.
- `outstanding` counter:
  - +1 on an accepted read; -1 on `master_readdatavalid`; both in one cycle leaves it unchanged.
  - Width is `$clog2(MAX_OUTSTANDING+1)`; it never wraps.
- `master_readdata` and `master_readdatavalid` pass combinationally to `rd_readdata` and `rd_readdatavalid` in every state, including `S_WRITE`.
- A response arriving with `outstanding == 0` is still forwarded, sets `protocol_error`, and leaves the counter at 0.

## Timing
- Reset (`reset`=0 at an edge):
  - state = `S_IDLE`, `last_grant` = 1 (read wins the first tie), `beats` = 0, `outstanding` = 0, `protocol_error` = 0.
  - Outputs then read: `master_read`/`master_write` = 0, both waitrequests = 1, `idle` = 1.
- Reset mid-operation drops the grant at once. Responses to pre-reset reads are forwarded and flag `protocol_error`.
- Arbitration latency is 1 cycle: a request seen in `S_IDLE` is forwarded in the next cycle. Each release costs a 1-cycle bubble.
- Within a grant, back-to-back accepts occur every cycle while `master_waitrequest` = 0.
- Request-path outputs are combinational from registered state and the granted port's inputs. Read responses have zero added latency.

## Structure
- Package `rasterizer_mem_pkg` holds `arb_state_t` and the constants `SDRAM_ADDR_W=26`, `SDRAM_DATA_W=32`, `SDRAM_BE_W=4`. The fetch and writeback stages share this package.
- Single module, no sub-modules. The counters and round-robin pick are small enough to stay inline.

## Test plan
- **Single read**: `rd_read` to 0x000100, `master_waitrequest`=0, data 0xDEADBEEF returned 3 cycles later.
  - `master_read` is high 1 cycle after the request, `outstanding` goes 1 then 0, `rd_readdata`=0xDEADBEEF, `idle` returns to 1.
- **Both request continuously** from reset, `MAX_BEATS`=8.
  - 8 reads, 1 bubble, 8 writes, 1 bubble, repeating. The first grant is the read port.
- **Outstanding limit**: 6 back-to-back reads with no responses, `MAX_OUTSTANDING`=4.
  - 4 accepted, `rd_waitrequest`=1 from the 5th. Each response re-enables one read.
  - With `wr_write` high, the arbiter moves to `S_WRITE` after the 4th read.
- **Waitrequest during a grant**: `master_waitrequest`=1 for 5 cycles during a write at beat 8 with reads pending.
  - No release and `wr_writedata` held stable until accept, then release.
- **Simultaneous accept and response** at `outstanding`=2: count stays 2. A stray `master_readdatavalid` at 0 sets `protocol_error`, which stays set until reset.
- **Reset asserted during `S_READ`** with 3 reads outstanding.
  - Next cycle all reset values hold. The first late response sets `protocol_error`.
